// File: rtl/bus_target_sram_pkg.sv
// Shared definitions for the bus target SRAM: bus field widths, FSM state
// encodings and the address-decode helper constants.
package bus_target_sram_pkg;

    localparam int DATA_W     = 32;
    localparam int BE_W       = 4;
    localparam int BURST_W    = 8;
    localparam int WORD_SHIFT = 2;

    localparam logic [BE_W-1:0] FULL_MASK = 4'hF;

    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_WRITE    = 3'd1;
    localparam logic [2:0] ST_RD_FETCH = 3'd2;
    localparam logic [2:0] ST_RD_DATA  = 3'd3;
    localparam logic [2:0] ST_RD_END   = 3'd4;
    localparam logic [2:0] ST_ERROR    = 3'd5;

endpackage

// File: rtl/bus_target_sram_mem.sv
// Single-port synchronous SRAM, Depth x 32, per-byte write enables and
// registered read data that only changes when a read is requested.
module bus_target_mem
    import bus_target_sram_pkg::*;
#(
    parameter int AddrWidth = 9
) (
    input  logic                 clk_i,
    input  logic [AddrWidth-1:0] addr_i,
    input  logic [BE_W-1:0]      we_i,
    input  logic                 re_i,
    input  logic [DATA_W-1:0]    wdata_i,
    output logic [DATA_W-1:0]    rdata_o
);

    localparam int Depth = 1 << AddrWidth;

    logic [DATA_W-1:0] mem_q [Depth];
    logic [DATA_W-1:0] rdata_q;

    // Read data holds its value between reads so a stalled beat stays stable.
    always_ff @(posedge clk_i) begin
        for (int b = 0; b < BE_W; b++) begin
            if (we_i[b]) begin
                mem_q[addr_i][8*b +: 8] <= wdata_i[8*b +: 8];
            end
        end
        if (re_i) begin
            rdata_q <= mem_q[addr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/bus_target_sram.sv
// Bus target answering single/burst reads and writes to an SRAM-backed window
// at Base. All outputs stay 0 unless this target is serving a transaction.
module bus_target_sram
    import bus_target_sram_pkg::*;
#(
    parameter logic [31:0] Base      = 32'h40000000,
    parameter int          AddrWidth = 9
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [DATA_W-1:0]   address_dataIN,
    input  logic [BE_W-1:0]     byte_enableIN,
    input  logic [BURST_W-1:0]  burst_sizeIN,
    input  logic                read_n_writeIN,
    input  logic                begin_transactionIN,
    input  logic                end_transactionIN,
    input  logic                data_validIN,
    input  logic                busyIN,
    input  logic                errorIN,
    output logic [DATA_W-1:0]   address_dataOUT,
    output logic                end_transactionOUT,
    output logic                data_validOUT,
    output logic                busyOUT,
    output logic                errorOUT
);

    localparam int          Depth     = 1 << AddrWidth;
    localparam int          CHK_W     = AddrWidth + 9;
    localparam int          BEAT_W    = BURST_W + 1;
    localparam logic [31:0] WIN_BYTES = 32'(1) << (AddrWidth + WORD_SHIFT);

    logic [2:0]           state_q, state_d;
    logic [AddrWidth-1:0] waddr_q, waddr_d;
    logic [BEAT_W-1:0]    cnt_q, cnt_d;
    logic [BURST_W-1:0]   burst_q, burst_d;
    logic [BE_W-1:0]      be_q, be_d;

    logic [31:0]          offset;
    logic                 hit, misaligned, overrun;
    logic [AddrWidth-1:0] dec_waddr;
    logic [CHK_W-1:0]     last_word;

    logic [AddrWidth-1:0] mem_addr;
    logic [BE_W-1:0]      mem_we;
    logic                 mem_re;
    logic [DATA_W-1:0]    mem_rdata;

    // Addresses below Base wrap to a huge offset, so one compare covers both ends.
    assign offset     = address_dataIN - Base;
    assign hit        = offset < WIN_BYTES;
    assign dec_waddr  = offset[AddrWidth+WORD_SHIFT-1:WORD_SHIFT];
    assign misaligned = |address_dataIN[WORD_SHIFT-1:0];
    assign last_word  = CHK_W'(dec_waddr) + CHK_W'(burst_sizeIN);
    assign overrun    = last_word > CHK_W'(Depth - 1);

    always_comb begin
        state_d  = state_q;
        waddr_d  = waddr_q;
        cnt_d    = cnt_q;
        burst_d  = burst_q;
        be_d     = be_q;
        mem_addr = waddr_q;
        mem_we   = '0;
        mem_re   = 1'b0;
        if (errorIN) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (begin_transactionIN && hit) begin
                        waddr_d = dec_waddr;
                        burst_d = burst_sizeIN;
                        cnt_d   = '0;
                        be_d    = (burst_sizeIN == '0) ? byte_enableIN : FULL_MASK;
                        if (misaligned || overrun) begin
                            state_d = ST_ERROR;
                        end else if (read_n_writeIN) begin
                            state_d = ST_RD_FETCH;
                        end else begin
                            state_d = ST_WRITE;
                        end
                    end
                end
                ST_WRITE: begin
                    if (data_validIN && (cnt_q <= {1'b0, burst_q})) begin
                        mem_we  = be_q;
                        waddr_d = waddr_q + AddrWidth'(1);
                        cnt_d   = cnt_q + BEAT_W'(1);
                    end
                    if (end_transactionIN) begin
                        state_d = ST_IDLE;
                    end
                end
                ST_RD_FETCH: begin
                    mem_re  = 1'b1;
                    state_d = end_transactionIN ? ST_IDLE : ST_RD_DATA;
                end
                ST_RD_DATA: begin
                    if (end_transactionIN) begin
                        state_d = ST_IDLE;
                    end else if (!busyIN) begin
                        if (cnt_q == {1'b0, burst_q}) begin
                            state_d = ST_RD_END;
                        end else begin
                            // Prefetch on acceptance keeps the burst at one beat per cycle.
                            mem_re   = 1'b1;
                            mem_addr = waddr_q + AddrWidth'(1);
                            waddr_d  = waddr_q + AddrWidth'(1);
                            cnt_d    = cnt_q + BEAT_W'(1);
                        end
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            waddr_q <= '0;
            cnt_q   <= '0;
            burst_q <= '0;
            be_q    <= '0;
        end else begin
            state_q <= state_d;
            waddr_q <= waddr_d;
            cnt_q   <= cnt_d;
            burst_q <= burst_d;
            be_q    <= be_d;
        end
    end

    bus_target_mem #(
        .AddrWidth(AddrWidth)
    ) u_mem (
        .clk_i  (clock),
        .addr_i (mem_addr),
        .we_i   (mem_we),
        .re_i   (mem_re),
        .wdata_i(address_dataIN),
        .rdata_o(mem_rdata)
    );

    // errorIN gates every output combinationally so the bus clears that cycle.
    assign data_validOUT      = (state_q == ST_RD_DATA) && !errorIN;
    assign address_dataOUT    = data_validOUT ? mem_rdata : '0;
    assign end_transactionOUT = (state_q == ST_RD_END) && !errorIN;
    assign errorOUT           = (state_q == ST_ERROR) && !errorIN;
    assign busyOUT            = 1'b0;

endmodule

// File: doc/bus_target_sram.md
Name: bus_target_sram

Overview:
- Bus responder (target) for the shared transaction bus. Answers single and burst reads and writes from any initiator (e.g. the DMA engine) to a memory-mapped window at Base.
- The window is backed by an internal word-wide SRAM with byte enables.
- Sits on the bus side of the arbiter, in parallel with other targets. All outputs are 0 whenever the block is not addressed, so outputs can be OR-combined.

Parameters:
- Base, 32'h40000000, byte address of the window start; must be aligned to 4*Depth.
- AddrWidth, 9, word-address width; Depth = 2**AddrWidth words (512 words = 2 KiB window).

Ports:
- clock  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- address_dataIN  in  32  address on the begin cycle, write data on data cycles
- byte_enableIN  in  4  byte lanes, sampled on the begin cycle
- burst_sizeIN  in  8  beats minus 1, sampled on the begin cycle
- read_n_writeIN  in  1  1 = read, sampled on the begin cycle
- begin_transactionIN  in  1  transaction start
- end_transactionIN  in  1  initiator end of write / abort
- data_validIN  in  1  write beat valid
- busyIN  in  1  initiator stalls read data
- errorIN  in  1  bus error, aborts everything
- address_dataOUT  out  32  read data
- end_transactionOUT  out  1  end of read burst
- data_validOUT  out  1  read beat valid
- busyOUT  out  1  write stall (always 0 in this version)
- errorOUT  out  1  target error response

Behaviour:
- Reset: all outputs 0, FSM in IDLE, address/count registers 0. SRAM contents are undefined.
- Decode happens on the cycle with begin_transactionIN=1 while in IDLE:
  - hit = address_dataIN in [Base, Base+4*Depth).
  - Miss → stay IDLE, drive nothing.
  - begin_transactionIN in any other state is ignored.
- Error condition on a hit: address[1:0]≠0, OR word_addr+burst_size > Depth-1 (no wrap-around).
  - Response: ERROR state, errorOUT=1 for exactly one cycle (the cycle after begin), then IDLE.
  - No SRAM access is performed.
- States: IDLE, WRITE, RD_FETCH, RD_DATA, RD_END, ERROR.
- Write path (IDLE → WRITE):
  - Each cycle with data_validIN=1 writes address_dataIN to SRAM[word_addr], then word_addr+1 and beat_cnt+1.
  - Lane mask: byte_enableIN latched on begin if burst_size=0; 4'hF for bursts.
  - Beats beyond burst_size+1 are ignored (not written).
  - end_transactionIN=1 → IDLE. A data beat in the same cycle is still written.
  - busyOUT held 0.
- Read path (IDLE → RD_FETCH → RD_DATA):
  - RD_FETCH: SRAM read of the first word; 1-cycle synchronous read latency.
  - RD_DATA: data_validOUT=1 and address_dataOUT=word, every cycle.
  - A beat is accepted when data_validOUT=1 and busyIN=0. On acceptance, prefetch the next word so back-to-back beats run at 1 beat/cycle.
  - busyIN=1 → hold the same data and address; do not advance.
  - After burst_size+1 accepted beats → RD_END: end_transactionOUT=1 for one cycle with data_validOUT=0, then IDLE.
  - First read data appears 2 cycles after the begin cycle.
  - Read-data byte lanes are not masked by byte_enable.
- errorIN=1 in any state → IDLE next cycle; all outputs drop to 0 that same cycle (combinational gating). A write beat in that cycle is not committed.
- end_transactionIN during a read → treated as abort → IDLE.
- Reset asserted mid-transaction → immediate return to IDLE and outputs 0. SRAM writes already committed persist.
- Width rules: word_addr = (address-Base)[AddrWidth+1:2]. The burst bound is checked in AddrWidth+9 bits to avoid overflow.

Decomposition:
- Shared bus package holds:
  - State encoding localparams.
  - Bus field widths (32 data, 4 byte-enable, 8 burst).
  - Decode helper constants: WORD_SHIFT=2, FULL_MASK=4'hF.
- Sub-module bus_target_mem: single-port synchronous SRAM, Depth×32, per-byte write enables, registered read data.
- The FSM, address/beat counters and decode stay in bus_target_sram.

Test Plan:
1. Single write 0x40000010 data 0xDEADBEEF be=4'hF, end with the data beat; then single read of the same address → data_validOUT=1 with 0xDEADBEEF 2 cycles after begin, end_transactionOUT the cycle after.
2. Single write be=4'b0011 data 0x11223344 over 0xDEADBEEF; read back → 0xDEAD3344.
3. Burst write of 4 beats (burst_size=3) at Base with 1..4, then burst read with busyIN=1 on beat 2 for 3 cycles → beats 1,2,3,4 in order, beat 2 held stable for 3 cycles, exactly 4 accepted beats, then end_transactionOUT.
4. Read at Base+2 (misaligned), and burst_size=3 at Base+0x7F8 (crosses the end of the window) → errorOUT=1 for one cycle each, no data_validOUT, SRAM unchanged. Address 0x3FFFFFFC → no response at all.
5. errorIN pulsed during beat 2 of a 4-beat write → beats 3 and 4 not written, FSM in IDLE next cycle, outputs 0.
6. reset low mid-RD_DATA → outputs 0 within the same cycle; a subsequent begin is served normally.
